// File: rtl/net_argmax.sv
// net_argmax: classifier stage behind the `net` inference block.
// On a rising edge of done_in it snapshots the flat O x 32-bit vector y,
// then scans one element per clock for the largest value. The index and
// value of the winner are published with a one-cycle valid pulse exactly
// O clocks after the trigger edge.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   done_in    `net` done level; a rising edge starts a classification
//   y          flat vector, element i = y[32*i+31:32*i]
//   class_idx  index of the max element of the last completed scan
//   max_val    value of that element
//   valid      one-cycle pulse: class_idx/max_val just updated
//   busy       high while a scan is in progress
//   overrun    one-cycle pulse: trigger edge dropped because busy
module net_argmax #(
    parameter int unsigned O     = 10,
    parameter bit          FLOAT = 1'b0,
    localparam int unsigned IW   = (O > 1) ? $clog2(O) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_in,
    input  logic [32*O-1:0]   y,
    output logic [IW-1:0]     class_idx,
    output logic [31:0]       max_val,
    output logic              valid,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned DW   = 32;
    localparam logic [IW-1:0] LAST = IW'(O - 1);
    localparam logic [IW-1:0] FIRST_SCAN = (O > 1) ? IW'(1) : IW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            done_q;
    logic [DW-1:0]   buf_q [O];
    logic [DW-1:0]   best_val;
    logic [IW-1:0]   best_idx;
    logic [IW-1:0]   i;

    logic            trig_c;
    logic [DW-1:0]   elem_c;
    logic            greater_c;

    // Order-preserving key: an unsigned compare of keys gives the signed
    // (or IEEE-754 total-order) compare of the raw values.
    function automatic logic [DW-1:0] sort_key(input logic [DW-1:0] x);
        logic [DW-1:0] k;
        if (FLOAT) begin
            k = x[DW-1] ? ~x : {1'b1, x[DW-2:0]};
        end else begin
            k = {~x[DW-1], x[DW-2:0]};
        end
        return k;
    endfunction

    // Rising-edge detect on the upstream done level.
    assign trig_c = done_in & ~done_q;

    // Current candidate and strict-greater test (ties keep the lower index).
    assign elem_c    = buf_q[i];
    assign greater_c = sort_key(elem_c) > sort_key(best_val);

    // Scan controller, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            best_val  <= '0;
            best_idx  <= '0;
            i         <= '0;
            class_idx <= '0;
            max_val   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned k = 0; k < O; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            done_q  <= done_in;
            valid   <= 1'b0;
            overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (trig_c) begin
                        // y is sampled only here; later changes are ignored.
                        for (int unsigned k = 0; k < O; k++) begin
                            buf_q[k] <= y[DW*k +: DW];
                        end
                        best_val <= y[DW-1:0];
                        best_idx <= '0;
                        i        <= FIRST_SCAN;
                        busy     <= 1'b1;
                        state    <= (O == 1) ? DONE : SCAN;
                    end
                end

                SCAN: begin
                    if (trig_c) begin
                        overrun <= 1'b1;
                    end
                    if (greater_c) begin
                        best_val <= elem_c;
                        best_idx <= i;
                    end
                    if (i == LAST) begin
                        state <= DONE;
                    end else begin
                        i <= i + IW'(1);
                    end
                end

                DONE: begin
                    // Publish the result; this edge is O clocks after trigger.
                    if (trig_c) begin
                        overrun <= 1'b1;
                    end
                    class_idx <= best_idx;
                    max_val   <= best_val;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    i         <= '0;
                    state     <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_net_argmax.sv
// Testbench for net_argmax: one integer-compare and one float-compare
// instance share stimulus; a bench model pushes expected results into
// per-instance queues, and a monitor pops and compares them on valid.
module tb_net_argmax;

    localparam int unsigned O   = 10;
    localparam int unsigned LAT = 10;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] val;
        int          trig;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              done_in;
    logic [32*O-1:0]   y;

    logic [3:0]  ci0, ci1;
    logic [31:0] mv0, mv1;
    logic        v0, v1, b0, b1, o0, o1;

    logic [31:0] ya [O];
    exp_t        q0 [$];
    exp_t        q1 [$];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int ov0    = 0;
    int ov1    = 0;

    net_argmax #(.O(O), .FLOAT(1'b0)) dut_int (
        .clk(clk), .rst_n(rst_n), .done_in(done_in), .y(y),
        .class_idx(ci0), .max_val(mv0), .valid(v0), .overrun(o0), .busy(b0)
    );

    net_argmax #(.O(O), .FLOAT(1'b1)) dut_flt (
        .clk(clk), .rst_n(rst_n), .done_in(done_in), .y(y),
        .class_idx(ci1), .max_val(mv1), .valid(v1), .overrun(o1), .busy(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ordering written independently of the DUT's key trick.
    function automatic bit gt(input logic [31:0] a, input logic [31:0] b, input bit flt);
        if (!flt) return $signed(a) > $signed(b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a > b;
        return a < b;
    endfunction

    function automatic exp_t model(input bit flt, input int trig);
        exp_t e;
        e.idx  = 4'd0;
        e.val  = ya[0];
        e.trig = trig;
        for (int k = 1; k < O; k++) begin
            if (gt(ya[k], e.val, flt)) begin
                e.idx = 4'(k);
                e.val = ya[k];
            end
        end
        return e;
    endfunction

    task automatic set_y();
        for (int k = 0; k < O; k++) y[32*k +: 32] = ya[k];
    endtask

    // Expected result for a trigger sampled at the next rising edge.
    task automatic push_expected();
        q0.push_back(model(1'b0, cyc + 1));
        q1.push_back(model(1'b1, cyc + 1));
    endtask

    task automatic fire();
        @(negedge clk);
        set_y();
        done_in = 1'b1;
        push_expected();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic run();
        fire();
        repeat (2) @(negedge clk);
        done_in = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (v0) begin
            if (q0.size() == 0) check("spurious_valid_int", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("idx_int", 32'(ci0), 32'(e.idx));
                check("val_int", mv0, e.val);
                check("lat_int", 32'(cyc - e.trig), 32'(LAT));
            end
        end
        if (v1) begin
            if (q1.size() == 0) check("spurious_valid_flt", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("idx_flt", 32'(ci1), 32'(e.idx));
                check("val_flt", mv1, e.val);
                check("lat_flt", 32'(cyc - e.trig), 32'(LAT));
            end
        end
        if (o0) ov0++;
        if (o1) ov1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int s0, s1;

        rst_n   = 1'b0;
        done_in = 1'b0;
        y       = '0;
        for (int k = 0; k < O; k++) ya[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_idx", 32'(ci0), 32'd0);
        check("rst_val", mv0, 32'd0);
        check("rst_busy_valid", {30'd0, b0 | b1, v0 | v1}, 32'd0);
        check("rst_ovr", 32'(o0 | o1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ascending ramp: busy duration and no overrun.
        for (int k = 0; k < O; k++) ya[k] = 32'(k);
        fire();
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) done_in = 1'b0;
            if (v0) break;
            if (b0) cnt++;
        end
        check("busy_cycles", 32'(cnt), 32'(LAT));
        wait_drain();
        check("ovr_none", 32'(ov0 + ov1), 32'd0);
        repeat (2) @(negedge clk);

        // Ties keep lowest index; all-equal keeps index 0.
        for (int k = 0; k < O; k++) ya[k] = '0;
        ya[3] = 32'h5; ya[7] = 32'h5;
        run();
        for (int k = 0; k < O; k++) ya[k] = 32'hFFFF_FFFF;
        run();

        // Signed extremes.
        for (int k = 0; k < O; k++) ya[k] = '0;
        ya[0] = 32'h7FFF_FFFF; ya[1] = 32'h8000_0000;
        run();
        for (int k = 0; k < O; k++) ya[k] = 32'hFFFF_FFFE;
        ya[0] = 32'h8000_0000;
        run();

        // Float ordering including -0 vs +0.
        for (int k = 0; k < O; k++) ya[k] = 32'hBF80_0000;
        ya[2] = 32'hC000_0000; ya[5] = 32'h3F80_0000; ya[8] = 32'h8000_0000;
        run();
        for (int k = 0; k < O; k++) ya[k] = 32'hC040_0000;
        ya[0] = 32'h8000_0000; ya[1] = 32'h0000_0000;
        run();

        // Random patterns.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < O; k++) ya[k] = $urandom;
            run();
        end

        // Retrigger while busy plus y changing after the sample edge.
        s0 = ov0; s1 = ov1;
        for (int k = 0; k < O; k++) ya[k] = $urandom;
        fire();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) for (int k = 0; k < O; k++) y[32*k +: 32] = $urandom | 32'h7000_0000;
            if (c == 2) done_in = 1'b0;
            if (c == 4) done_in = 1'b1;
            if (c == 6) done_in = 1'b0;
        end
        wait_drain();
        repeat (15) @(negedge clk);
        #2;
        check("overrun_int", 32'(ov0 - s0), 32'd1);
        check("overrun_flt", 32'(ov1 - s1), 32'd1);

        // Make sure the held result is nonzero before the reset test.
        for (int k = 0; k < O; k++) ya[k] = '0;
        ya[6] = 32'h4000_0000;
        run();

        // Reset five cycles into a scan; done_in left high through reset.
        for (int k = 0; k < O; k++) ya[k] = $urandom;
        fire();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check("midrst_idx", 32'(ci0), 32'd0);
        check("midrst_val", mv1, 32'd0);
        check("midrst_busy", 32'(b0 | b1 | v0 | v1), 32'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < O; k++) ya[k] = 32'(100 - k * 7);
        ya[4] = 32'h0000_1234;
        set_y();
        rst_n = 1'b1;
        push_expected();
        repeat (2) @(negedge clk);
        done_in = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        for (int k = 0; k < O; k++) ya[k] = $urandom;
        run();
        repeat (12) @(negedge clk);
        #2;
        check("end_queues", 32'(q0.size() + q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/net_argmax.md
Name: net_argmax

Overview:
- Classifier stage directly downstream of the `net` inference block.
- Consumes the flat O×32-bit output vector `y` when `net` raises `done`.
- Scans the elements sequentially, one comparison per cycle, and reports the index and value of the largest element.
- Produces a one-cycle `valid` pulse per classification. A host or bench reads the predicted digit from it.

Parameters:
- O, 10, number of 32-bit output elements (must be ≥1; matches `net` O).
- FLOAT, 0, 0 = elements compared as signed two's-complement 32-bit; 1 = elements compared as IEEE-754 single.
- IW, $clog2(O) (min 1), width of class index (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- done_in  in  1  `net` done level; rising edge triggers capture.
- y  in  32*O  flat vector; element i = y[32*i+31:32*i].
- class_idx  out  IW  index of max element of last completed scan.
- max_val  out  32  value of that element.
- valid  out  1  one-cycle pulse: class_idx/max_val just updated.
- busy  out  1  high while a scan is in progress (state ≠ IDLE).
- overrun  out  1  one-cycle pulse: trigger edge dropped because busy.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, done_q=0, all internal regs=0.
  - Outputs: class_idx=0, max_val=0, valid=0, busy=0, overrun=0.
  - Reset mid-scan aborts the scan. No valid is produced for it.
- Edge detect:
  - done_q registers done_in each cycle.
  - trig = done_in & ~done_q.
  - If done_in is already high at reset release, it counts as an edge on the first clock.
- States:
  - IDLE → SCAN on trig. At that edge T: latch all of y into internal buffer, best_val=elem0, best_idx=0, i=1. Use IDLE → DONE instead when O=1.
  - SCAN: one element per edge, at edges T+1 … T+O-1. If elem[i] > best_val (strict), then best_val=elem[i] and best_idx=i. Then i++. After i=O-1 is processed → DONE.
  - DONE → IDLE unconditionally. On the edge entering DONE (edge T+O), update class_idx=best_idx and max_val=best_val, and set valid=1.
- valid timing:
  - High exactly one cycle, from edge T+O to edge T+O+1.
  - class_idx/max_val hold until the next DONE entry or reset.
- Latency: trigger edge to valid = exactly O clocks (10 for default).
- Data stability: y is sampled only at T. Changes on y after T do not affect the result.
- Ties: the lowest index wins (strict greater-than).
- Compare, FLOAT=0: signed 32-bit compare.
- Compare, FLOAT=1:
  - Map each value to a key: if bit31=1, invert all bits; else set bit31=1. Then compare keys unsigned.
  - Effects: -0 < +0. NaNs order by bit pattern (positive NaN above +inf, negative NaN below -inf). No exceptions.
- Busy and overrun:
  - busy=1 in SCAN and DONE.
  - trig while busy (including in the DONE cycle) is ignored: the scan continues undisturbed and overrun pulses 1 cycle.
  - trig in IDLE starts a new scan.
  - valid and trig may coincide only as trig in DONE, which is an overrun.
- Counter: i is IW bits wide and never exceeds O-1. There is no wrap.

Test Plan:
1. Reset, then done_in rises with y element k = k (k=0..9), FLOAT=0 → valid exactly 10 clocks after trigger edge, class_idx=9, max_val=0x00000009, busy high 10 cycles, overrun never asserted.
2. y all zero except elem3=0x00000005 and elem7=0x00000005 → class_idx=3 (tie keeps lowest); then all elements 0xFFFFFFFF (-1) → class_idx=0, max_val=0xFFFFFFFF.
3. Signed check, FLOAT=0: elem0=0x7FFFFFFF, elem1=0x80000000, others 0 → class_idx=0. Repeat with elem0=0x80000000, others 0xFFFFFFFE → class_idx=1, max_val=0xFFFFFFFE.
4. FLOAT=1: elem2=0xC0000000 (-2.0), elem5=0x3F800000 (1.0), elem8=0x80000000 (-0), others 0xBF800000 (-1.0) → class_idx=5, max_val=0x3F800000. Then elem0=0x80000000, elem1=0x00000000, others negative → class_idx=1.
5. done_in toggled low→high again 4 cycles after the first trigger, and y changed after T → overrun pulse one cycle at that edge, no second valid, result reflects y latched at T.
6. rst_n pulled low at trigger+5 → outputs immediately 0, busy=0, no valid. After release, a fresh trigger classifies correctly with 10-cycle latency.
